// File: rtl/event_encoder_8to3.sv
// Sticky 8-line event capture serialised as binary codes over a valid/ready handshake.
// Optional macro ENC_ROUND_ROBIN_EN switches code selection from lowest-index-first to round-robin.
module event_encoder_8to3 #(
  parameter int N      = 8,
  parameter int CODE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      evt_in,
  output logic [CODE_W-1:0] out_code,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      pending,
  output logic              overflow
);

  typedef enum logic {IDLE, HOLD} state_t;

  state_t            state_reg;
  logic [N-1:0]      pending_reg;
  logic [CODE_W-1:0] code_reg;
  logic              valid_reg;
  logic              overflow_reg;

  logic              accept;
  logic [N-1:0]      served;
  logic [N-1:0]      rem;
  logic [CODE_W-1:0] sel_code;

  assign accept = valid_reg & out_ready;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_served
      assign served[gi] = accept && (code_reg == CODE_W'(gi));
    end
  endgenerate

  // In IDLE nothing is served, so rem equals pending and one selector covers both states.
  assign rem = pending_reg & ~served;

  function automatic logic [CODE_W-1:0] lowest_index(input logic [N-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

`ifdef ENC_ROUND_ROBIN_EN
  logic [CODE_W-1:0] ptr_reg;
  logic [CODE_W-1:0] ptr_next;
  logic [2*N-1:0]    doubled;
  logic [N-1:0]      rotated;

  // The pointer advanced by this cycle's accept already steers the back-to-back pick.
  assign ptr_next = accept ? code_reg + CODE_W'(1) : ptr_reg;
  assign doubled  = {rem, rem} >> ptr_next;
  assign rotated  = doubled[N-1:0];
  // N is a power of two, so the CODE_W-bit sum wraps modulo N on its own.
  assign sel_code = lowest_index(rotated) + ptr_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_reg <= '0;
    end else begin
      ptr_reg <= ptr_next;
    end
  end
`else
  assign sel_code = lowest_index(rem);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      code_reg     <= '0;
      valid_reg    <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      pending_reg  <= rem | evt_in;
      overflow_reg <= |(evt_in & rem);
      case (state_reg)
        IDLE: begin
          if (|pending_reg) begin
            code_reg  <= sel_code;
            valid_reg <= 1'b1;
            state_reg <= HOLD;
          end
        end
        HOLD: begin
          if (accept) begin
            if (|rem) begin
              code_reg <= sel_code;
            end else begin
              valid_reg <= 1'b0;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign out_code  = code_reg;
  assign out_valid = valid_reg;
  assign pending   = pending_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_event_encoder_8to3.sv
// Scoreboard bench for event_encoder_8to3: a set-based reference model queues expectations,
// a negedge monitor pops and compares them against the DUT.
module tb_event_encoder_8to3;
  localparam int N  = 8;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  evt_in = '0;
  logic          out_ready = 1'b0;
  logic [CW-1:0] out_code;
  logic          out_valid;
  logic [N-1:0]  pending;
  logic          overflow;

  event_encoder_8to3 #(.N(N), .CODE_W(CW)) dut (
    .clk(clk), .rst(rst), .evt_in(evt_in), .out_code(out_code),
    .out_valid(out_valid), .out_ready(out_ready), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         valid;
    int           code;
    logic [N-1:0] pend;
    logic         ovf;
  } stat_t;

  stat_t stat_q[$];
  int    code_q[$];
  int    checks = 0;
  int    passed = 0;

  // Reference model: set of pending lines, the code on offer (if any), and the RR start point.
  logic [N-1:0] m_pend;
  logic         m_valid;
  int           m_code;
  logic         m_ovf;
  int           m_ptr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int start);
    for (int k = 0; k < N; k++) begin
      if (v[(start + k) % N]) return (start + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    m_pend = '0; m_valid = 1'b0; m_code = 0; m_ovf = 1'b0; m_ptr = 0;
  endtask

  // Called just after a rising edge: records what the DUT should show now, drives the inputs
  // for the coming edge and advances the model across it.
  task automatic step(input logic [N-1:0] evt, input logic rdy);
    stat_t        s;
    logic         acc;
    logic [N-1:0] rem;
    int           start;
    s.valid = m_valid; s.code = m_code; s.pend = m_pend; s.ovf = m_ovf;
    stat_q.push_back(s);
    acc = m_valid && rdy;
    if (acc) code_q.push_back(m_code);
    evt_in    = evt;
    out_ready = rdy;
    rem = m_pend;
    if (acc) rem[m_code] = 1'b0;
    m_ovf = |(evt & rem);
    start = 0;
`ifdef ENC_ROUND_ROBIN_EN
    if (acc) m_ptr = (m_code + 1) % N;
    start = m_ptr;
`endif
    if (!m_valid) begin
      if (rem != '0) begin
        m_valid = 1'b1;
        m_code  = pick(rem, start);
      end
    end else if (acc) begin
      if (rem != '0) m_code = pick(rem, start);
      else m_valid = 1'b0;
    end
    m_pend = rem | evt;
    @(posedge clk);
    #1;
  endtask

  stat_t mon_s;
  always @(negedge clk) begin
    if (stat_q.size() > 0) begin
      mon_s = stat_q.pop_front();
      check("out_valid", int'(out_valid), int'(mon_s.valid));
      check("pending", int'(pending), int'(mon_s.pend));
      check("overflow", int'(overflow), int'(mon_s.ovf));
      if (mon_s.valid) check("out_code", int'(out_code), mon_s.code);
      if (out_valid && out_ready) begin
        if (code_q.size() == 0) check("unexpected_accept", 1, 0);
        else check("accepted_code", int'(out_code), code_q.pop_front());
      end
    end
  end

  task automatic reset_mid_cycle();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("rst_pending", int'(pending), 0);
    check("rst_valid", int'(out_valid), 0);
    check("rst_code", int'(out_code), 0);
    check("rst_overflow", int'(overflow), 0);
    evt_in = '1;
    @(posedge clk);
    #1;
    check("rst_hold_pending", int'(pending), 0);
    check("rst_hold_valid", int'(out_valid), 0);
    rst       = 1'b0;
    evt_in    = '0;
    out_ready = 1'b0;
    model_clear();
  endtask

  initial begin
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check("init_valid", int'(out_valid), 0);
    check("init_pending", int'(pending), 0);
    rst = 1'b0;

    // Single event, free-running consumer.
    step(8'h20, 1'b1);
    repeat (4) step(8'h00, 1'b1);

    // Priority with backpressure.
    step(8'h91, 1'b0);
    repeat (4) step(8'h00, 1'b0);
    repeat (5) step(8'h00, 1'b1);

    // Overflow while stalled, then re-event in the accept cycle of code 3.
    step(8'h08, 1'b0);
    repeat (2) step(8'h00, 1'b0);
    step(8'h08, 1'b0);
    step(8'h00, 1'b0);
    step(8'h08, 1'b1);
    repeat (4) step(8'h00, 1'b1);

    // All-ones burst.
    step(8'hFF, 1'b1);
    repeat (11) step(8'h00, 1'b1);

    // Held pair of lines: starvation vs. alternation depends on selection mode.
    repeat (8) step(8'h03, 1'b1);
    repeat (4) step(8'h00, 1'b1);

    // Asynchronous reset with a full pending register on offer.
    repeat (3) step(8'hFF, 1'b0);
    reset_mid_cycle();
    repeat (3) step(8'h00, 1'b1);

    // Randomised traffic and backpressure.
    for (int i = 0; i < 400; i++) begin
      logic [N-1:0] e;
      e = ($urandom_range(0, 2) == 0) ? N'($urandom) & N'($urandom) : '0;
      step(e, $urandom_range(0, 3) != 0);
    end
    repeat (12) step(8'h00, 1'b1);

    @(negedge clk);
    #1;
    check("stat_queue_drained", stat_q.size(), 0);
    check("code_queue_drained", code_q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
